csr_trap: RTL

CSR_TRAP -- requirements
Module: csr_trap

---
 rtl/csr_trap.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/csr_trap.sv
// ============================================================================
//  Module   : csr_trap
//  Brief    : Machine-mode CSR file with trap entry/return, external
//             interrupt pending logic and 64-bit cycle/instret counters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module csr_trap #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trap_taken,
    input  logic [4:0]  trap_src,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        trap_return,
    input  logic        retire,
    input  logic        external_int,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic [31:0] mtvec_rdata,
    output logic [31:0] mepc_rdata,
    output logic        int_pending
);

    localparam logic [11:0] c_ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] c_ADDR_MIE       = 12'h304;
    localparam logic [11:0] c_ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] c_ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] c_ADDR_MEPC      = 12'h341;
    localparam logic [11:0] c_ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] c_ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] c_ADDR_MIP       = 12'h344;
    localparam logic [11:0] c_ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] c_ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] c_ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] c_ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] c_ADDR_MHARTID   = 12'hF14;

    localparam logic [1:0]  c_OP_NONE  = 2'b00;
    localparam logic [1:0]  c_OP_WRITE = 2'b01;
    localparam logic [1:0]  c_OP_SET   = 2'b10;
    localparam logic [1:0]  c_OP_CLEAR = 2'b11;

    localparam logic [31:0] c_LOW2_MASK = 32'hFFFF_FFFC;

    // Architectural state
    logic        r_mie;
    logic        r_mpie;
    logic        r_meie;
    logic        r_meip;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [31:0] r_mcycle_lo;
    logic [31:0] r_mcycle_hi;
    logic [31:0] r_minstret_lo;
    logic [31:0] r_minstret_hi;

    // Combinational helpers
    logic [31:0] w_rdata;
    logic        w_supported;
    logic [31:0] w_new;
    logic        w_csr_we;
    logic [63:0] w_mcycle_inc;
    logic [63:0] w_minstret_inc;
    logic        w_tval_keep;

    // Read mux: current (pre-update) value and address decode
    always_comb begin
        w_rdata     = 32'h0000_0000;
        w_supported = 1'b1;
        case (csr_addr)
            c_ADDR_MSTATUS:   w_rdata = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
            c_ADDR_MIE:       w_rdata = {20'b0, r_meie, 11'b0};
            c_ADDR_MTVEC:     w_rdata = r_mtvec & c_LOW2_MASK;
            c_ADDR_MSCRATCH:  w_rdata = r_mscratch;
            c_ADDR_MEPC:      w_rdata = r_mepc & c_LOW2_MASK;
            c_ADDR_MCAUSE:    w_rdata = r_mcause;
            c_ADDR_MTVAL:     w_rdata = r_mtval;
            c_ADDR_MIP:       w_rdata = {20'b0, r_meip, 11'b0};
            c_ADDR_MCYCLE:    w_rdata = r_mcycle_lo;
            c_ADDR_MCYCLEH:   w_rdata = r_mcycle_hi;
            c_ADDR_MINSTRET:  w_rdata = r_minstret_lo;
            c_ADDR_MINSTRETH: w_rdata = r_minstret_hi;
            c_ADDR_MHARTID:   w_rdata = HART_ID;
            default:          w_supported = 1'b0;
        endcase
    end

    // Operand combine, legality check and write enable
    always_comb begin
        case (csr_op)
            c_OP_WRITE: w_new = csr_wdata;
            c_OP_SET:   w_new = w_rdata | csr_wdata;
            c_OP_CLEAR: w_new = w_rdata & ~csr_wdata;
            default:    w_new = w_rdata;
        endcase
        csr_illegal = (csr_op != c_OP_NONE) &&
                      (!w_supported ||
                       ((csr_op == c_OP_WRITE) && (csr_addr[11:10] == 2'b11)));
        // Traps and returns take priority and swallow any CSR op in the same cycle
        w_csr_we    = (csr_op != c_OP_NONE) && !csr_illegal && !trap_taken && !trap_return;
        w_tval_keep = (trap_src == 5'h00) || (trap_src == 5'h04) || (trap_src == 5'h06);
        w_mcycle_inc   = {r_mcycle_hi, r_mcycle_lo} + 64'd1;
        w_minstret_inc = {r_minstret_hi, r_minstret_lo} + 64'd1;
    end

    assign csr_rdata   = w_rdata;
    assign mtvec_rdata = r_mtvec & c_LOW2_MASK;
    assign mepc_rdata  = r_mepc & c_LOW2_MASK;
    assign int_pending = r_meip & r_meie & r_mie;

    // Trap entry/return and software CSR updates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_meie     <= 1'b0;
            r_mtvec    <= MTVEC_RESET & c_LOW2_MASK;
            r_mscratch <= 32'h0;
            r_mepc     <= 32'h0;
            r_mcause   <= 32'h0;
            r_mtval    <= 32'h0;
        end else if (trap_taken) begin
            r_mepc   <= trap_pc & c_LOW2_MASK;
            r_mcause <= {trap_src[4], 27'b0, trap_src[3:0]};
            r_mtval  <= w_tval_keep ? trap_tval : 32'h0;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (trap_return) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_csr_we) begin
            case (csr_addr)
                c_ADDR_MSTATUS: begin
                    r_mie  <= w_new[3];
                    r_mpie <= w_new[7];
                end
                c_ADDR_MIE:      r_meie     <= w_new[11];
                c_ADDR_MTVEC:    r_mtvec    <= w_new & c_LOW2_MASK;
                c_ADDR_MSCRATCH: r_mscratch <= w_new;
                c_ADDR_MEPC:     r_mepc     <= w_new & c_LOW2_MASK;
                c_ADDR_MCAUSE:   r_mcause   <= w_new;
                c_ADDR_MTVAL:    r_mtval    <= w_new;
                default: ;
            endcase
        end
    end

    // External interrupt level synchroniser into mip.MEIP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meip <= 1'b0;
        end else begin
            r_meip <= external_int;
        end
    end

    // mcycle: free-running, a write to one half holds the other half
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcycle_lo <= 32'h0;
            r_mcycle_hi <= 32'h0;
        end else if (w_csr_we && (csr_addr == c_ADDR_MCYCLE)) begin
            r_mcycle_lo <= w_new;
        end else if (w_csr_we && (csr_addr == c_ADDR_MCYCLEH)) begin
            r_mcycle_hi <= w_new;
        end else begin
            {r_mcycle_hi, r_mcycle_lo} <= w_mcycle_inc;
        end
    end

    // minstret: counts retirements, same override rules as mcycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_minstret_lo <= 32'h0;
            r_minstret_hi <= 32'h0;
        end else if (w_csr_we && (csr_addr == c_ADDR_MINSTRET)) begin
            r_minstret_lo <= w_new;
        end else if (w_csr_we && (csr_addr == c_ADDR_MINSTRETH)) begin
            r_minstret_hi <= w_new;
        end else if (retire) begin
            {r_minstret_hi, r_minstret_lo} <= w_minstret_inc;
        end
    end

endmodule

`default_nettype wire
